// File: rtl/s2mm_wr_ctrl.sv
// s2mm_wr_ctrl: turns a single write request (byte address + length in
// 64-bit beats) into one DataMover S2MM command. The request's write data is
// passed through to the S2MM stream, and the DataMover status is collected
// and reduced to a two-bit AXI-style write response.
//
// Ports
//   clk, rstn               clock, asynchronous active-low reset
//   wreq_*                  request handshake: address and size in beats
//   wdata_*                 write-data stream from the requester
//   wresp_valid, wresp      one-cycle response pulse (00 OKAY, 10 SLVERR, 11 DECERR)
//   m_axis_s2mm_cmd_*       DataMover command stream
//   m_axis_s2mm_*           DataMover data stream (pass-through of wdata)
//   s_axis_s2mm_sts_*       DataMover status stream
module s2mm_wr_ctrl #(
  parameter int S2MM_ADDR_WIDTH = 32,
  parameter int S2MM_SIZE_WIDTH = 16,
  parameter int S2MM_DATA_WIDTH = 64,
  parameter int S2MM_CMD_WIDTH  = 72,
  parameter int S2MM_STS_WIDTH  = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  output logic                       wreq_ready,
  input  logic                       wreq_valid,
  input  logic [S2MM_ADDR_WIDTH-1:0] wreq_addr,
  input  logic [S2MM_SIZE_WIDTH-1:0] wreq_size,
  output logic                       wdata_ready,
  input  logic                       wdata_valid,
  input  logic                       wdata_last,
  input  logic [S2MM_DATA_WIDTH-1:0] wdata,
  output logic                       wresp_valid,
  output logic [1:0]                 wresp,
  output logic                       m_axis_s2mm_cmd_tvalid,
  input  logic                       m_axis_s2mm_cmd_tready,
  output logic [S2MM_CMD_WIDTH-1:0]  m_axis_s2mm_cmd_tdata,
  output logic                       m_axis_s2mm_tvalid,
  input  logic                       m_axis_s2mm_tready,
  output logic [63:0]                m_axis_s2mm_tdata,
  output logic [7:0]                 m_axis_s2mm_tkeep,
  output logic                       m_axis_s2mm_tlast,
  input  logic                       s_axis_s2mm_sts_tvalid,
  output logic                       s_axis_s2mm_sts_tready,
  input  logic [S2MM_STS_WIDTH-1:0]  s_axis_s2mm_sts_tdata
);

  typedef enum logic [2:0] {IDLE, CMD, DATA, STS, RESP} state_t;

  localparam logic [S2MM_SIZE_WIDTH-1:0] ONE = {{(S2MM_SIZE_WIDTH-1){1'b0}}, 1'b1};

  state_t                     state;
  logic [S2MM_SIZE_WIDTH-1:0] size_r;
  logic [S2MM_SIZE_WIDTH-1:0] beat_cnt;
  logic [3:0]                 tag;
  logic [3:0]                 cur_tag;
  logic                       len_err;
  logic [15:0]                wd_cnt;
  logic [1:0]                 resp_code;
  logic                       in_data;
  logic                       final_beat;
  logic                       beat_hs;
  logic                       unused_sts_bits;

  // Command word: BTT in bytes (beats * 8), INCR burst, EOF set, 32-bit
  // address field and the 4-bit tag used to match the returning status.
  function automatic logic [S2MM_CMD_WIDTH-1:0] build_cmd(
    input logic [S2MM_ADDR_WIDTH-1:0] a,
    input logic [S2MM_SIZE_WIDTH-1:0] s,
    input logic [3:0]                 t
  );
    logic [22:0] btt;
    logic [31:0] a32;
    logic [71:0] c;
    btt = 23'({s, 3'b000});
    a32 = 32'(a);
    c   = {4'h0, t, a32, 1'b0, 1'b1, 6'h00, 1'b1, btt};
    return S2MM_CMD_WIDTH'(c);
  endfunction

  // Status decode in priority order; a status with none of the result bits
  // set is treated as a slave error rather than silently reported OKAY.
  function automatic logic [1:0] decode_sts(
    input logic [7:0] sts,
    input logic [3:0] exp_tag,
    input logic       lerr
  );
    if ((sts[3:0] != exp_tag) || sts[4]) return 2'b10;
    else if (sts[5])                     return 2'b11;
    else if (sts[6])                     return 2'b10;
    else if (sts[7])                     return lerr ? 2'b10 : 2'b00;
    else                                 return 2'b10;
  endfunction

  assign unused_sts_bits = ^s_axis_s2mm_sts_tdata[S2MM_STS_WIDTH-1:8];

  // Data phase is a pure pass-through gated by the state; tlast comes from
  // the beat count so a misplaced wdata_last cannot truncate the burst.
  assign in_data            = (state == DATA);
  assign final_beat         = (beat_cnt == size_r - ONE);
  assign beat_hs            = in_data & wdata_valid & m_axis_s2mm_tready;
  assign m_axis_s2mm_tvalid = in_data & wdata_valid;
  assign wdata_ready        = in_data & m_axis_s2mm_tready;
  assign m_axis_s2mm_tdata  = wdata;
  assign m_axis_s2mm_tkeep  = 8'hFF;
  assign m_axis_s2mm_tlast  = in_data & final_beat;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state                  <= IDLE;
      wreq_ready             <= 1'b1;
      wresp_valid            <= 1'b0;
      wresp                  <= 2'b00;
      m_axis_s2mm_cmd_tvalid <= 1'b0;
      m_axis_s2mm_cmd_tdata  <= '0;
      s_axis_s2mm_sts_tready <= 1'b0;
      size_r                 <= '0;
      beat_cnt               <= '0;
      tag                    <= 4'h0;
      cur_tag                <= 4'h0;
      len_err                <= 1'b0;
      wd_cnt                 <= 16'h0000;
      resp_code              <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          // The response pulse from the previous request lives in this cycle.
          wresp_valid <= 1'b0;
          if (wreq_valid) begin
            size_r     <= wreq_size;
            len_err    <= 1'b0;
            wreq_ready <= 1'b0;
            if (wreq_size == '0) begin
              resp_code <= 2'b10;
              state     <= RESP;
            end else begin
              m_axis_s2mm_cmd_tdata  <= build_cmd(wreq_addr, wreq_size, tag);
              m_axis_s2mm_cmd_tvalid <= 1'b1;
              state                  <= CMD;
            end
          end
        end
        CMD: begin
          if (m_axis_s2mm_cmd_tready) begin
            m_axis_s2mm_cmd_tvalid <= 1'b0;
            cur_tag                <= tag;
            tag                    <= tag + 4'd1;
            state                  <= DATA;
          end
        end
        DATA: begin
          if (beat_hs) begin
            if (final_beat) begin
              len_err                <= len_err | ~wdata_last;
              beat_cnt               <= '0;
              wd_cnt                 <= 16'h0000;
              s_axis_s2mm_sts_tready <= 1'b1;
              state                  <= STS;
            end else begin
              len_err  <= len_err | wdata_last;
              beat_cnt <= beat_cnt + ONE;
            end
          end
        end
        STS: begin
          if (s_axis_s2mm_sts_tvalid) begin
            resp_code              <= decode_sts(s_axis_s2mm_sts_tdata[7:0], cur_tag, len_err);
            s_axis_s2mm_sts_tready <= 1'b0;
            state                  <= RESP;
          end else if (wd_cnt == 16'hFFFF) begin
            // DataMover never answered: report a decode error and recover.
            resp_code              <= 2'b11;
            s_axis_s2mm_sts_tready <= 1'b0;
            state                  <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end
        RESP: begin
          wresp       <= resp_code;
          wresp_valid <= 1'b1;
          wreq_ready  <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_s2mm_wr_ctrl.sv
module tb_s2mm_wr_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        wreq_ready;
  logic        wreq_valid = 1'b0;
  logic [31:0] wreq_addr = '0;
  logic [15:0] wreq_size = '0;
  logic        wdata_ready;
  logic        wdata_valid = 1'b0;
  logic        wdata_last = 1'b0;
  logic [63:0] wdata = '0;
  logic        wresp_valid;
  logic [1:0]  wresp;
  logic        cmd_tvalid;
  logic        cmd_tready = 1'b0;
  logic [71:0] cmd_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tlast;
  logic        sts_tvalid = 1'b0;
  logic        sts_tready;
  logic [31:0] sts_tdata = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  s2mm_wr_ctrl dut (
    .clk                    (clk),
    .rstn                   (rstn),
    .wreq_ready             (wreq_ready),
    .wreq_valid             (wreq_valid),
    .wreq_addr              (wreq_addr),
    .wreq_size              (wreq_size),
    .wdata_ready            (wdata_ready),
    .wdata_valid            (wdata_valid),
    .wdata_last             (wdata_last),
    .wdata                  (wdata),
    .wresp_valid            (wresp_valid),
    .wresp                  (wresp),
    .m_axis_s2mm_cmd_tvalid (cmd_tvalid),
    .m_axis_s2mm_cmd_tready (cmd_tready),
    .m_axis_s2mm_cmd_tdata  (cmd_tdata),
    .m_axis_s2mm_tvalid     (m_tvalid),
    .m_axis_s2mm_tready     (m_tready),
    .m_axis_s2mm_tdata      (m_tdata),
    .m_axis_s2mm_tkeep      (m_tkeep),
    .m_axis_s2mm_tlast      (m_tlast),
    .s_axis_s2mm_sts_tvalid (sts_tvalid),
    .s_axis_s2mm_sts_tready (sts_tready),
    .s_axis_s2mm_sts_tdata  (sts_tdata)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  function automatic logic [71:0] exp_cmd(input logic [31:0] a, input logic [15:0] s,
                                          input logic [3:0] t);
    return {4'h0, t, a, 1'b0, 1'b1, 6'h00, 1'b1, 4'h0, s, 3'b000};
  endfunction

  task automatic req(input logic [31:0] a, input logic [15:0] s);
    wreq_addr  = a;
    wreq_size  = s;
    wreq_valid = 1'b1;
    tick;
    wreq_valid = 1'b0;
  endtask

  task automatic do_cmd(input logic [71:0] exp, input string nm);
    chk({nm, "_cmd_tvalid"}, 72'(cmd_tvalid), 72'd1);
    chk({nm, "_cmd_tdata"}, cmd_tdata, exp);
    chk({nm, "_wreq_ready_busy"}, 72'(wreq_ready), 72'd0);
    cmd_tready = 1'b1;
    tick;
    cmd_tready = 1'b0;
    chk({nm, "_cmd_tvalid_drop"}, 72'(cmd_tvalid), 72'd0);
  endtask

  task automatic drive_beats(input int n, input int last_at, input bit toggle,
                             input logic [31:0] base, input string nm);
    int i;
    int cyc;
    i = 0;
    cyc = 0;
    while (i < n && cyc < 64) begin
      m_tready    = toggle ? (cyc % 2 == 0) : 1'b1;
      wdata_valid = 1'b1;
      wdata       = {base, 32'(i)};
      wdata_last  = (i == last_at);
      #1;
      if (m_tready) begin
        chk({nm, "_tvalid"}, 72'(m_tvalid), 72'd1);
        chk({nm, "_wdata_ready"}, 72'(wdata_ready), 72'd1);
        chk({nm, "_tdata"}, 72'(m_tdata), 72'({base, 32'(i)}));
        chk({nm, "_tlast"}, 72'(m_tlast), 72'(i == n - 1));
      end else begin
        chk({nm, "_no_ready_while_stalled"}, 72'(wdata_ready), 72'd0);
      end
      @(posedge clk);
      #1;
      if (m_tready) i++;
      cyc++;
    end
    wdata_valid = 1'b0;
    wdata_last  = 1'b0;
    m_tready    = 1'b0;
    chk({nm, "_beat_count"}, 72'(i), 72'(n));
  endtask

  task automatic do_status(input logic [7:0] sts, input logic [1:0] exp, input string nm);
    chk({nm, "_sts_tready"}, 72'(sts_tready), 72'd1);
    sts_tvalid = 1'b1;
    sts_tdata  = 32'(sts);
    tick;
    sts_tvalid = 1'b0;
    chk({nm, "_sts_tready_drop"}, 72'(sts_tready), 72'd0);
    chk({nm, "_wresp_valid_early"}, 72'(wresp_valid), 72'd0);
    tick;
    chk({nm, "_wresp_valid"}, 72'(wresp_valid), 72'd1);
    chk({nm, "_wresp"}, 72'(wresp), 72'(exp));
    tick;
    chk({nm, "_wresp_pulse_end"}, 72'(wresp_valid), 72'd0);
    chk({nm, "_idle_ready"}, 72'(wreq_ready), 72'd1);
  endtask

  initial begin
    int n;
    tick;
    tick;
    chk("rst_wreq_ready", 72'(wreq_ready), 72'd1);
    chk("rst_wresp_valid", 72'(wresp_valid), 72'd0);
    chk("rst_wresp", 72'(wresp), 72'd0);
    chk("rst_cmd_tvalid", 72'(cmd_tvalid), 72'd0);
    chk("rst_cmd_tdata", cmd_tdata, 72'd0);
    chk("rst_sts_tready", 72'(sts_tready), 72'd0);
    chk("rst_m_tvalid", 72'(m_tvalid), 72'd0);
    chk("rst_tkeep", 72'(m_tkeep), 72'hFF);
    rstn = 1'b1;
    tick;

    // Basic 4-beat write, OKAY status.
    req(32'h1000_0000, 16'd4);
    do_cmd(72'h0_0_10000000_40800020, "basic");
    drive_beats(4, 3, 1'b0, 32'hA000_0000, "basic");
    do_status(8'h80, 2'b00, "basic");

    // Zero-length request: no command, SLVERR two cycles after request.
    req(32'h2000_0000, 16'd0);
    chk("zero_no_cmd", 72'(cmd_tvalid), 72'd0);
    chk("zero_wresp_early", 72'(wresp_valid), 72'd0);
    tick;
    chk("zero_no_cmd2", 72'(cmd_tvalid), 72'd0);
    chk("zero_wresp_valid", 72'(wresp_valid), 72'd1);
    chk("zero_wresp", 72'(wresp), 72'd2);
    tick;
    chk("zero_pulse_end", 72'(wresp_valid), 72'd0);

    // Early wdata_last: burst length unchanged, length error reported.
    req(32'h0000_1000, 16'd4);
    do_cmd(exp_cmd(32'h0000_1000, 16'd4, 4'd1), "early_last");
    drive_beats(4, 1, 1'b0, 32'hB000_0000, "early_last");
    do_status(8'h81, 2'b10, "early_last");

    // Back-pressure toggling each cycle on an 8-beat burst.
    req(32'h0004_0000, 16'd8);
    do_cmd(exp_cmd(32'h0004_0000, 16'd8, 4'd2), "toggle");
    drive_beats(8, 7, 1'b1, 32'hC000_0000, "toggle");
    do_status(8'h82, 2'b00, "toggle");

    // DECERR outranks OKAY.
    req(32'h0000_0040, 16'd2);
    do_cmd(exp_cmd(32'h0000_0040, 16'd2, 4'd3), "decerr");
    drive_beats(2, 1, 1'b0, 32'hD000_0000, "decerr");
    do_status(8'hA3, 2'b11, "decerr");

    // Tag mismatch in an otherwise OKAY status.
    req(32'h0000_0080, 16'd1);
    do_cmd(exp_cmd(32'h0000_0080, 16'd1, 4'd4), "tagmis");
    drive_beats(1, 0, 1'b0, 32'hE000_0000, "tagmis");
    do_status(8'h85, 2'b10, "tagmis");

    // Status never arrives: watchdog fires with DECERR.
    req(32'h0000_0100, 16'd1);
    do_cmd(exp_cmd(32'h0000_0100, 16'd1, 4'd5), "wdog");
    drive_beats(1, 0, 1'b0, 32'hF000_0000, "wdog");
    n = 0;
    while (!wresp_valid && n < 70000) begin
      tick;
      n++;
    end
    chk("wdog_cycles", 72'(n), 72'd65537);
    chk("wdog_wresp", 72'(wresp), 72'd3);
    chk("wdog_idle", 72'(wreq_ready), 72'd1);
    tick;
    chk("wdog_pulse_end", 72'(wresp_valid), 72'd0);

    // Reset asserted mid-burst aborts without a response.
    req(32'h0000_2000, 16'd4);
    do_cmd(exp_cmd(32'h0000_2000, 16'd4, 4'd6), "abort");
    m_tready    = 1'b1;
    wdata_valid = 1'b1;
    wdata       = 64'h1234_5678_9ABC_DEF0;
    tick;
    tick;
    #2;
    rstn = 1'b0;
    #1;
    chk("abort_wreq_ready", 72'(wreq_ready), 72'd1);
    chk("abort_cmd_tvalid", 72'(cmd_tvalid), 72'd0);
    chk("abort_cmd_tdata", cmd_tdata, 72'd0);
    chk("abort_sts_tready", 72'(sts_tready), 72'd0);
    chk("abort_m_tvalid", 72'(m_tvalid), 72'd0);
    chk("abort_wdata_ready", 72'(wdata_ready), 72'd0);
    chk("abort_tlast", 72'(m_tlast), 72'd0);
    chk("abort_wresp", 72'(wresp), 72'd0);
    chk("abort_wresp_valid", 72'(wresp_valid), 72'd0);
    m_tready    = 1'b0;
    wdata_valid = 1'b0;
    tick;
    tick;
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("abort_no_resp", 72'(wresp_valid), 72'd0);
    end

    // 17 requests after reset: tags 0..15 then wrap to 0.
    for (int r = 0; r < 17; r++) begin
      req(32'h0010_0000 + 32'(r * 8), 16'd1);
      do_cmd(exp_cmd(32'h0010_0000 + 32'(r * 8), 16'd1, 4'(r)), "tagseq");
      drive_beats(1, 0, 1'b0, 32'(r), "tagseq");
      do_status({4'h8, 4'(r)}, 2'b00, "tagseq");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/s2mm_wr_ctrl.md
S2MM_WR_CTRL -- requirements
Module: s2mm_wr_ctrl

Interface
REQ-001 SHALL have parameter S2MM_ADDR_WIDTH, default 32, meaning the byte address width of a write request.
REQ-002 SHALL have parameter S2MM_SIZE_WIDTH, default 16, meaning the request length width in 64-bit beats.
REQ-003 SHALL have parameter S2MM_DATA_WIDTH, default 64, meaning the data width, fixed at 64.
REQ-004 SHALL have parameter S2MM_CMD_WIDTH, default 72, meaning the DataMover command width.
REQ-005 SHALL have parameter S2MM_STS_WIDTH, default 32, meaning the status width; only bits [7:0] are used.
REQ-006 SHALL have ports clk in 1 (the single clock) and rstn in 1 (asynchronous, active-low reset).
REQ-007 SHALL have request ports: wreq_ready out 1; wreq_valid in 1; wreq_addr in S2MM_ADDR_WIDTH; wreq_size in S2MM_SIZE_WIDTH (beats).
REQ-008 SHALL have write-data ports: wdata_ready out 1; wdata_valid in 1; wdata_last in 1; wdata in S2MM_DATA_WIDTH.
REQ-009 SHALL have response ports: wresp_valid out 1; wresp out 2 (00 OKAY, 10 SLVERR, 11 DECERR).
REQ-010 SHALL have command ports: m_axis_s2mm_cmd_tvalid out 1; m_axis_s2mm_cmd_tready in 1; m_axis_s2mm_cmd_tdata out S2MM_CMD_WIDTH.
REQ-011 SHALL have stream ports: m_axis_s2mm_tvalid out 1; m_axis_s2mm_tready in 1; m_axis_s2mm_tdata out 64; m_axis_s2mm_tkeep out 8; m_axis_s2mm_tlast out 1.
REQ-012 SHALL have status ports: s_axis_s2mm_sts_tvalid in 1; s_axis_s2mm_sts_tready out 1; s_axis_s2mm_sts_tdata in S2MM_STS_WIDTH.

Function
REQ-013 SHALL implement FSM states IDLE, CMD, DATA, STS, RESP, one-hot or binary.
REQ-014 IDLE: wreq_ready=1; on wreq_valid, SHALL latch addr and size, clear len_err, and go to CMD; if size==0, SHALL go to RESP with wresp=10 and issue no command.
REQ-015 wreq_ready SHALL be 0 outside IDLE; wreq_valid outside IDLE SHALL be ignored with no state change.
REQ-016 Command layout: [22:0] BTT={size,3'b000}, zero-extended; [23]=1 INCR; [29:24]=0; [30]=1 EOF; [31]=0; [63:32]=addr; [67:64]=tag; [71:68]=0.
REQ-017 CMD: cmd_tvalid=1 with tdata stable until cmd_tready; on the handshake, SHALL go to DATA.
REQ-018 DATA, pass-through: m_axis_s2mm_tvalid=wdata_valid, tdata=wdata, tkeep=8'hFF, and wdata_ready=m_axis_s2mm_tready; outside DATA, wdata_ready=0 and m_axis_s2mm_tvalid=0.
REQ-019 A 16-bit beat counter SHALL increment per accepted beat; tlast SHALL be 1 exactly when count==size-1, independent of wdata_last.
REQ-020 len_err SHALL be set if wdata_last=1 on an accepted beat other than the final one, or if wdata_last=0 on the final beat.
REQ-021 After the final beat handshake, the FSM SHALL go to STS and reset the counter to 0.
REQ-022 STS: sts_tready=1; on sts_tvalid, SHALL go to RESP and decode in priority order: tag mismatch or INTERR[4] -> 10; DECERR[5] -> 11; SLVERR[6] -> 10; OKAY[7] -> 00 (10 if len_err).
REQ-023 STS watchdog: a 16-bit counter SHALL clear on entry; on reaching 16'hFFFF without status, SHALL go to RESP with wresp=11.
REQ-024 RESP: wresp_valid=1 for exactly one cycle, wresp held until the next response; then IDLE.
REQ-025 The 4-bit tag SHALL increment after each accepted command and wrap 15->0.
REQ-026 Request-to-cmd_tvalid latency SHALL be 1 cycle; last-beat-to-sts_tready latency SHALL be 1 cycle.

Reset
REQ-027 On rstn=0, SHALL enter IDLE with: wreq_ready=1; wresp_valid=0; wresp=00; cmd_tvalid=0; cmd_tdata=0; tag=0; counters=0; len_err=0; sts_tready=0; m_axis_s2mm_tvalid=0.
REQ-028 Reset mid-transfer SHALL abort immediately, with no response generated for the aborted request.

Verification
REQ-029 addr=0x1000_0000, size=4, ready=1, OKAY status tag 0 -> cmd_tdata=72'h0_0_10000000_40800020; 4 beats with tlast on beat 3; wresp_valid pulse with wresp=00.
REQ-030 size=0 -> no cmd_tvalid; wresp_valid with wresp=10 two cycles after the request.
REQ-031 size=4, wdata_last on beat 1 -> tlast still on beat 3; wresp=10 despite OKAY status.
REQ-032 m_axis_s2mm_tready toggling 1/0 each cycle, size=8 -> exactly 8 beats with data order preserved; no wdata_ready while tready=0.
REQ-033 Status with DECERR -> wresp=11; no status for 65535 cycles -> wresp=11 and FSM returns to IDLE.
REQ-034 17 back-to-back requests -> tags 0..15 then 0; rstn pulsed during DATA -> all outputs at reset values, no wresp_valid.
